fetch_stage: RTL

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, loads it from the externally supplied start address after reset, and fetches instructions over a request/acknowledge instruction-memory port. It presents fetched instructions to decode through the IF/ID pipeline register, honours hazard-unit stalls with a one-entry hold buffer, and accepts branch/jump redirects from EX.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/fetch_stage_if_id_reg.sv | 35 +++
 rtl/fetch_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared across the MIPS pipeline stages.
//   fetch_state_t : fetch stage FSM states (INIT, FETCH, HOLD)
//   PC_STEP       : program counter increment per instruction
//   NOP_INSTR     : instruction word written into IF/ID on a flush
//   if_id_t       : IF/ID pipeline register payload, shared with decode
package mips_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load enable, bubble and flush.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   flush      : clear valid and replace the instruction with NOP_INSTR
//   load       : capture d
//   bubble     : clear valid only, payload kept
//   d          : next payload
//   q          : registered payload
// Priority: flush > load > bubble; with none asserted the register holds.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{valid: 1'b0, instr: NOP_INSTR, pc_plus4: 32'd0};
    end else if (flush) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (load) begin
      q <= d;
    end else if (bubble) begin
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Owns the program counter, fetches over a request/acknowledge instruction
// memory port, feeds decode through IF/ID, absorbs stalls with a one-entry
// hold buffer and accepts branch/jump redirects from EX.
// Ports:
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   pc_init           : start address, sampled in INIT
//   imem_req/addr     : fetch request and address (addr == program_counter)
//   imem_ack/rdata    : instruction valid for the current address
//   stall             : decode cannot accept, IF/ID holds
//   redirect_valid/pc : taken branch/jump target from EX
//   program_counter   : address of the next fetch
//   if_id_valid/instr/pc_plus4 : IF/ID register contents
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched and
// perf_stall_cycles counters.
module fetch_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_init,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] program_counter,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles
`else
  output logic [31:0] if_id_pc_plus4
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  hold_instr;
  logic [31:0]  hold_pc_plus4;
  logic         hold_load;
  logic         ifid_load;
  logic         ifid_flush;
  logic         ifid_bubble;
  logic         fetch_accept;
  if_id_t       ifid_d;
  if_id_t       ifid_q;

  assign pc_plus4 = program_counter + PC_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    imem_req     = 1'b0;
    pc_d         = program_counter;
    hold_load    = 1'b0;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_bubble  = 1'b0;
    fetch_accept = 1'b0;
    ifid_d       = '{valid: 1'b1, instr: imem_rdata, pc_plus4: pc_plus4};

    case (state_q)
      INIT: begin
        pc_d    = pc_init;
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        // A redirect wins over everything; an ack arriving with it is dropped.
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          ifid_flush = 1'b1;
          state_d    = FETCH;
        end else if (imem_ack) begin
          fetch_accept = 1'b1;
          pc_d         = pc_plus4;
          if (stall) begin
            hold_load = 1'b1;
            state_d   = HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          ifid_flush = 1'b1;
          state_d    = FETCH;
        end else if (!stall) begin
          ifid_d    = '{valid: 1'b1, instr: hold_instr, pc_plus4: hold_pc_plus4};
          ifid_load = 1'b1;
          state_d   = FETCH;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) program_counter <= 32'd0;
    else        program_counter <= pc_d;
  end

  // The buffer is only read while in HOLD, so leaving HOLD discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_instr    <= NOP_INSTR;
      hold_pc_plus4 <= 32'd0;
    end else if (hold_load) begin
      hold_instr    <= imem_rdata;
      hold_pc_plus4 <= pc_plus4;
    end
  end

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (ifid_flush),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign imem_addr      = program_counter;
  assign if_id_valid    = ifid_q.valid;
  assign if_id_instr    = ifid_q.instr;
  assign if_id_pc_plus4 = ifid_q.pc_plus4;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched      <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (fetch_accept)               perf_fetched      <= perf_fetched + 32'd1;
      if (stall && state_q != INIT)   perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = fetch_accept;
`endif

endmodule
